stdp_weight_update: RTL and testbench
=====================================

STDP_WEIGHT_UPDATE -- requirements
Module: stdp_weight_update

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pending weight-change requests buffered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  meaning the reset; asynchronous, active-low.
REQ-004 SHALL have port change_weight  input  1  meaning one-cycle request strobe from the STDP stage.
REQ-005 SHALL have port delta_w  input  fp::fpType  meaning the signed weight change, sampled when change_weight=1.
REQ-006 SHALL have port load_weight  input  1  meaning a synchronous load of weight_init.
REQ-007 SHALL have port weight_init  input  fp::fpType  meaning the value loaded by load_weight.
REQ-008 SHALL have ports w_min and w_max  input  fp::fpType  meaning the clip bounds.
REQ-009 SHALL have port weight  output  fp::fpType  meaning the current synaptic weight, fed back to the STDP stage.
REQ-010 SHALL have port update_done  output  1  meaning a one-cycle pulse in the cycle the weight changes due to a request.
REQ-011 SHALL have port busy  output  1  meaning the FSM is not IDLE or the FIFO is non-empty.
REQ-012 SHALL have port dropped  output  1  meaning a one-cycle pulse when a request is lost because the FIFO is full.
REQ-013 SHALL have port drop_count  output  8  meaning the saturating count of dropped requests.

Function
REQ-014 SHALL push delta_w into the FIFO when change_weight=1 and the FIFO is not full, or is full but popped in the same cycle.
REQ-015 SHALL otherwise discard the request, pulse dropped, and increment drop_count, holding it at 255.
REQ-016 SHALL run the FSM IDLE -> POP -> SUM -> CLIP -> COMMIT -> IDLE, leaving IDLE only when the FIFO is non-empty.
REQ-017 SHALL pop in POP.
REQ-018 SHALL form the sum in SUM as weight + delta at fp width + 1, sign-extended, with no wrap.
REQ-019 SHALL bound the sum in CLIP.
REQ-020 SHALL write weight and pulse update_done in COMMIT.
REQ-021 SHALL give a latency, from change_weight into an empty FIFO with the FSM in IDLE, such that the new weight is visible 5 clocks later with update_done high in that cycle.
REQ-022 SHALL process back-to-back requests sequentially, one per 5 cycles, each using the weight committed by the previous one.
REQ-023 SHALL give load_weight priority over everything except reset: weight <= weight_init, FIFO flushed, FSM to IDLE, no update_done; a change_weight in the same cycle SHALL be discarded without asserting dropped.
REQ-024 SHALL keep weight unchanged with update_done still pulsed when delta_w=0.

Reset
REQ-025 SHALL, on reset_n=0 and asynchronously, set weight=0, update_done=0, dropped=0, drop_count=0, FIFO empty and FSM IDLE.
REQ-026 SHALL abandon an in-flight update on reset mid-operation, with no partial commit.

Configuration
REQ-027 SHALL, with WEIGHT_CLIP_EN defined, clamp in CLIP to [w_min, w_max]; if w_min > w_max, the committed weight SHALL equal the old weight.
REQ-028 SHALL, without WEIGHT_CLIP_EN, ignore w_min and w_max and saturate only at the fp::fpType representable limits.

Structure
REQ-029 SHALL place the FSM state enum and the drop-counter width constant in package fp alongside fpType.
REQ-030 SHALL implement the buffer as sub-module weight_fifo, a synchronous FIFO with full and empty flags and simultaneous push/pop.

Verification (16-bit raw values, WIDTH=16)
REQ-031 SHALL cover: weight_init=100 load, then delta_w=+20 strobe -> weight=120 exactly 5 cycles later, with update_done pulsed once.
REQ-032 SHALL cover: WEIGHT_CLIP_EN, w_max=150, weight=120, delta_w=+50 -> weight=150; then delta_w=-200 with w_min=0 -> weight=0.
REQ-033 SHALL cover: no macro, weight=32760, delta_w=+100 -> weight=32767; weight=-32760, delta_w=-100 -> -32768.
REQ-034 SHALL cover: 6 strobes on consecutive cycles with FIFO_DEPTH=4 -> one request processed immediately, four buffered, one dropped; dropped pulses once, drop_count=1, final weight = the sum of the five applied deltas.
REQ-035 SHALL cover: load_weight=1 with weight_init=7 asserted in the SUM state with 2 entries pending -> weight=7 next cycle, busy=0, no update_done.
REQ-036 SHALL cover: reset_n dropped in the CLIP state -> weight=0 immediately, and after release no update_done occurs without a new strobe.

Source files
------------

// File: rtl/stdp_weight_update_pkg.sv
// Shared types for the STDP weight-update block: fixed-point weight type,
// update FSM states and drop-counter width.
package fp;
    localparam int FP_W = 16;
    typedef logic signed [FP_W-1:0] fpType;

    localparam int DROP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        SUM,
        CLIP,
        COMMIT
    } state_t;
endpackage

// File: rtl/stdp_weight_update_fifo.sv
// Synchronous request FIFO with full/empty flags, simultaneous push/pop and flush.
module weight_fifo
    import fp::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  flush,
    input  logic  push,
    input  logic  pop,
    input  fpType wdata,
    output fpType rdata,
    output logic  full,
    output logic  empty
);
    localparam int AW = $clog2(DEPTH);

    fpType         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/stdp_weight_update.sv
// Buffered STDP weight accumulator: IDLE->POP->SUM->CLIP->COMMIT per request.
// Define WEIGHT_CLIP_EN to clamp to [w_min, w_max] instead of fpType saturation.
module stdp_weight_update
    import fp::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              change_weight,
    input  fpType             delta_w,
    input  logic              load_weight,
    input  fpType             weight_init,
    input  fpType             w_min,
    input  fpType             w_max,
    output fpType             weight,
    output logic              update_done,
    output logic              busy,
    output logic              dropped,
    output logic [DROP_W-1:0] drop_count
);
    state_t                  state;
    state_t                  state_next;
    fpType                   fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic                    push;
    logic                    drop_now;
    fpType                   delta_p0;
    logic signed [FP_W:0]    sum_p1;
    fpType                   clip_p2;

`ifdef WEIGHT_CLIP_EN
    function automatic fpType bound(input logic signed [FP_W:0] s, input fpType lo,
                                    input fpType hi, input fpType old);
        // An inverted window is treated as "no legal move": keep the old weight.
        if (lo > hi)                  return old;
        if (s < (FP_W+1)'(lo))        return lo;
        if (s > (FP_W+1)'(hi))        return hi;
        return s[FP_W-1:0];
    endfunction
`else
    function automatic fpType bound(input logic signed [FP_W:0] s);
        if (s > (FP_W+1)'(fpType'({1'b0, {(FP_W-1){1'b1}}}))) return {1'b0, {(FP_W-1){1'b1}}};
        if (s < (FP_W+1)'(fpType'({1'b1, {(FP_W-1){1'b0}}}))) return {1'b1, {(FP_W-1){1'b0}}};
        return s[FP_W-1:0];
    endfunction

    logic unused_bounds;
    assign unused_bounds = ^{w_min, w_max};
`endif

    assign pop      = (state == POP) && !load_weight;
    assign push     = change_weight && !load_weight && (!fifo_full || pop);
    assign drop_now = change_weight && !load_weight && fifo_full && !pop;
    assign busy     = (state != IDLE) || !fifo_empty;

    weight_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .flush  (load_weight),
        .push   (push),
        .pop    (pop),
        .wdata  (delta_w),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         state <= IDLE;
        else if (load_weight) state <= IDLE;
        else                  state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = POP;
            POP:     state_next = SUM;
            SUM:     state_next = CLIP;
            CLIP:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // p0: popped delta, p1: widened sum, p2: bounded result
    always_ff @(posedge clk) begin
        if (state == POP) delta_p0 <= fifo_rdata;
        if (state == SUM) sum_p1   <= {weight[FP_W-1], weight} + {delta_p0[FP_W-1], delta_p0};
`ifdef WEIGHT_CLIP_EN
        if (state == CLIP) clip_p2 <= bound(sum_p1, w_min, w_max, weight);
`else
        if (state == CLIP) clip_p2 <= bound(sum_p1);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            weight      <= '0;
            update_done <= 1'b0;
            dropped     <= 1'b0;
            drop_count  <= '0;
        end else if (load_weight) begin
            weight      <= weight_init;
            update_done <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            update_done <= (state == COMMIT);
            if (state == COMMIT) weight <= clip_p2;
            dropped <= drop_now;
            if (drop_now && (drop_count != '1)) drop_count <= drop_count + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_stdp_weight_update.sv
// Directed self-checking bench for stdp_weight_update (clip or saturation build).
module tb_stdp_weight_update;
    import fp::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        change_weight;
    fpType       delta_w;
    logic        load_weight;
    fpType       weight_init;
    fpType       w_min;
    fpType       w_max;
    fpType       weight;
    logic        update_done;
    logic        busy;
    logic        dropped;
    logic [7:0]  drop_count;

    int tests = 0;
    int fails = 0;

    stdp_weight_update #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .change_weight(change_weight),
        .delta_w      (delta_w),
        .load_weight  (load_weight),
        .weight_init  (weight_init),
        .w_min        (w_min),
        .w_max        (w_max),
        .weight       (weight),
        .update_done  (update_done),
        .busy         (busy),
        .dropped      (dropped),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input fpType v);
        load_weight = 1'b1;
        weight_init = v;
        tick();
        load_weight = 1'b0;
    endtask

    // Strobe one request and wait the five clocks to its commit.
    task automatic apply(input fpType d);
        change_weight = 1'b1;
        delta_w       = d;
        tick();
        change_weight = 1'b0;
        repeat (4) tick();
        tick();
    endtask

    int drops;
    int dones;
    int guard;

    initial begin
        reset_n       = 1'b0;
        change_weight = 1'b0;
        delta_w       = '0;
        load_weight   = 1'b0;
        weight_init   = '0;
        w_min         = -16'sd1000;
        w_max         = 16'sd1000;
        repeat (2) tick();
        check("rst_weight", 32'(weight), 0);
        check("rst_done", 32'(update_done), 0);
        check("rst_dropped", 32'(dropped), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_busy", 32'(busy), 0);
        reset_n = 1'b1;
        tick();

        // Basic latency: 100 + 20 visible exactly 5 clocks after the strobe.
        load(16'sd100);
        check("load_100", 32'(weight), 100);
        change_weight = 1'b1;
        delta_w       = 16'sd20;
        tick();
        change_weight = 1'b0;
        repeat (3) tick();
        check("lat_busy", 32'(busy), 1);
        tick();
        check("lat_weight_before", 32'(weight), 100);
        check("lat_done_before", 32'(update_done), 0);
        tick();
        check("lat_weight", 32'(weight), 120);
        check("lat_done", 32'(update_done), 1);
        tick();
        check("lat_done_once", 32'(update_done), 0);
        check("lat_idle", 32'(busy), 0);

        apply(16'sd0);
        check("zero_delta_weight", 32'(weight), 120);
        check("zero_delta_done", 32'(update_done), 1);

`ifdef WEIGHT_CLIP_EN
        w_max = 16'sd150;
        w_min = 16'sd0;
        apply(16'sd50);
        check("clip_max", 32'(weight), 150);
        apply(-16'sd200);
        check("clip_min", 32'(weight), 0);
        apply(16'sd37);
        check("clip_inside", 32'(weight), 37);
        w_min = 16'sd100;
        w_max = 16'sd50;
        apply(16'sd5);
        check("clip_inverted", 32'(weight), 37);
        w_min = -16'sd1000;
        w_max = 16'sd1000;
`else
        w_max = 16'sd150;
        w_min = 16'sd0;
        apply(16'sd50);
        check("bounds_ignored", 32'(weight), 170);
        load(16'sd32760);
        apply(16'sd100);
        check("sat_pos", 32'(weight), 32767);
        load(-16'sd32760);
        apply(-16'sd100);
        check("sat_neg", 32'(weight), -32768);
        apply(16'sd300);
        check("after_sat_neg", 32'(weight), -32468);
`endif

        // Six consecutive strobes into a depth-4 FIFO: exactly the sixth is lost.
        load(16'sd0);
        drops = 0;
        dones = 0;
        for (int i = 1; i <= 6; i++) begin
            change_weight = 1'b1;
            delta_w       = fpType'(i);
            tick();
            if (dropped) drops++;
            if (update_done) dones++;
        end
        change_weight = 1'b0;
        guard = 0;
        while (busy && guard < 60) begin
            tick();
            guard++;
            if (dropped) drops++;
            if (update_done) dones++;
        end
        check("burst_drained", 32'(busy), 0);
        tick();
        if (update_done) dones++;
        check("burst_drop_pulses", drops, 1);
        check("burst_drop_count", 32'(drop_count), 1);
        check("burst_done_pulses", dones, 5);
        check("burst_weight", 32'(weight), 15);

        // Load while in SUM with two requests pending flushes everything.
        load(16'sd0);
        change_weight = 1'b1;
        delta_w = 16'sd10;
        tick();
        delta_w = 16'sd20;
        tick();
        delta_w = 16'sd30;
        tick();
        load_weight = 1'b1;
        weight_init = 16'sd7;
        delta_w     = 16'sd99;
        tick();
        load_weight   = 1'b0;
        change_weight = 1'b0;
        check("load_sum_weight", 32'(weight), 7);
        check("load_sum_busy", 32'(busy), 0);
        check("load_sum_done", 32'(update_done), 0);
        check("load_sum_dropped", 32'(dropped), 0);
        dones = 0;
        repeat (10) begin
            tick();
            if (update_done) dones++;
        end
        check("load_sum_no_done", dones, 0);
        check("load_sum_hold", 32'(weight), 7);
        check("load_sum_drop_count", 32'(drop_count), 1);

        // Asynchronous reset while in CLIP abandons the update.
        load(16'sd50);
        change_weight = 1'b1;
        delta_w       = 16'sd5;
        tick();
        change_weight = 1'b0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check("rst_clip_weight", 32'(weight), 0);
        check("rst_clip_busy", 32'(busy), 0);
        check("rst_clip_drop_count", 32'(drop_count), 0);
        tick();
        reset_n = 1'b1;
        dones = 0;
        repeat (10) begin
            tick();
            if (update_done) dones++;
        end
        check("rst_clip_no_done", dones, 0);
        check("rst_clip_hold", 32'(weight), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
